// File: rtl/sha256_msg_sequencer.sv
// Front end for a single-block SHA-256 compression core. It pads a word-aligned
// message, issues 512-bit blocks, chains the intermediate hashes and returns the digest.
module sha256_msg_sequencer #(
  parameter int unsigned      LEN_W = 16,
  parameter logic [7:0][31:0] IV    = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_words,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             core_start,
  output logic [7:0][31:0] core_h_init,
  output logic [511:0]     core_block,
  input  logic             core_done,
  input  logic [7:0][31:0] core_hash,
  output logic [7:0][31:0] digest,
  output logic             done,
  output logic             busy
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_FILL   | writing one block word per cycle (message, pad, zeros, length)
  // S_ISSUE  | one-cycle core_start pulse
  // S_WAIT   | block and chaining value held while the core computes
  // S_FINISH | done pulse, digest valid
  // Hash words are indexed so that element i is H_i.
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_FINISH} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [LEN_W:0]    g_q, g_d;
  logic [3:0]        k_q, k_d;
  logic [LEN_W-1:0]  blk_left_q, blk_left_d;
  logic [7:0][31:0]  chain_q, chain_d;
  logic [7:0][31:0]  digest_q, digest_d;
  logic [15:0][31:0] block_q, block_d;

  logic [LEN_W:0]    n_ext;
  logic [LEN_W:0]    n_plus2;
  logic [63:0]       len_bits;
  logic              last_blk;
  logic              fill_adv;
  logic [31:0]       fill_word;

  assign n_ext    = {1'b0, n_q};
  assign n_plus2  = {1'b0, msg_words} + (LEN_W+1)'(2);
  assign len_bits = {{(64-LEN_W-5){1'b0}}, n_q, 5'b0};
  assign last_blk = (blk_left_q == '0);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    g_d        = g_q;
    k_d        = k_q;
    blk_left_d = blk_left_q;
    chain_d    = chain_q;
    digest_d   = digest_q;
    block_d    = block_q;
    in_ready   = 1'b0;
    core_start = 1'b0;
    done       = 1'b0;
    fill_adv   = 1'b0;
    fill_word  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d        = msg_words;
          blk_left_d = LEN_W'(n_plus2 >> 4);
          chain_d    = IV;
          g_d        = '0;
          k_d        = '0;
          state_d    = S_FILL;
        end
      end

      S_FILL: begin
        if (g_q < n_ext) begin
          in_ready  = 1'b1;
          fill_adv  = in_valid;
          fill_word = in_data;
        end else begin
          fill_adv = 1'b1;
          if (g_q == n_ext)
            fill_word = 32'h8000_0000;
          else if (last_blk && k_q == 4'd14)
            fill_word = len_bits[63:32];
          else if (last_blk && k_q == 4'd15)
            fill_word = len_bits[31:0];
        end

        if (fill_adv) begin
          block_d[4'd15 - k_q] = fill_word;
          k_d = k_q + 4'd1;
          // g only needs to distinguish below/at/above N, so it stops at N+1.
          if (g_q <= n_ext)
            g_d = g_q + 1'b1;
          if (k_q == 4'd15)
            state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (core_done) begin
          chain_d = core_hash;
          if (last_blk) begin
            // Loading the digest here lets it be valid during the done pulse.
            digest_d = core_hash;
            state_d  = S_FINISH;
          end else begin
            blk_left_d = blk_left_q - 1'b1;
            k_d        = '0;
            state_d    = S_FILL;
          end
        end
      end

      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      g_q        <= '0;
      k_q        <= '0;
      blk_left_q <= '0;
      chain_q    <= IV;
      digest_q   <= '0;
      block_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      g_q        <= g_d;
      k_q        <= k_d;
      blk_left_q <= blk_left_d;
      chain_q    <= chain_d;
      digest_q   <= digest_d;
      block_q    <= block_d;
    end
  end

  assign core_block  = block_q;
  assign core_h_init = chain_q;
  assign digest      = digest_q;
  assign busy        = (state_q != S_IDLE);

endmodule
